noise_leakyrelu_stage: RTL and testbench
========================================

# noise_leakyrelu_stage

Post-convolution stage placed directly after the convolution engine's master AXI-Stream port. For each 48-bit bias-added accumulator it adds a per-pixel noise sample scaled by a per-channel weight, applies LeakyReLU (slope ≈ 0.2), then rounds and saturates to a 16-bit Q8.8 pixel. The result is streamed to the next layer's line buffers. It owns the noise BRAM and noise-scale BRAM read-address counters.

## Interface
Parameters:
- ACC_WIDTH, 48, accumulator width (Q32.16), taken from s_axis_tdata[ACC_WIDTH-1:0]
- DATA_WIDTH, 16, output / noise / scale width (Q8.8)
- SHIFT, 8, right shift applied when converting Q.16 to Q8.8

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- Image_size  in  8  feature-map side: 4, 8, 16, 32, 64 or 128
- Channel_size  in  9  channels per layer: 64, 128 or 256
- noise_en  in  1  0 forces the noise term to 0
- act_en  in  1  0 bypasses LeakyReLU
- noise_BRAM_addr  out  14  pixel index within the map
- noise_BRAM_en  out  1  noise BRAM read enable
- noise_BRAM_dout  in  16  noise sample, Q8.8, 1-cycle read latency
- noise_scale_BRAM_addr  out  8  channel index
- noise_scale_BRAM_en  out  1  scale BRAM read enable
- noise_scale_BRAM_dout  in  16  per-channel scale, Q8.8, 1-cycle latency
- s_axis_tdata  in  64  accumulator; bits [63:48] ignored
- s_axis_tvalid / s_axis_tready / s_axis_tlast  in/out/in  1  input stream
- m_axis_tdata  out  16  Q8.8 pixel
- m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1  output stream
- frame_error  out  1  sticky; set on a tlast/counter mismatch

## Operation
- Three-stage pipeline: S1 capture, S2 noise+activation, S3 round/saturate (output register). Each stage carries a valid bit and a tlast bit.
- Global advance: ce = ~reset & (~m_axis_tvalid | m_axis_tready). s_axis_tready = ce. An accept occurs when s_axis_tvalid & ce.
- On accept:
  - S1 captures acc and tlast.
  - noise_BRAM_en and noise_scale_BRAM_en are pulsed with address pix_cnt / ch_cnt.
  - Both BRAMs are enabled only on accept. Their dout holds while en=0, which keeps the data aligned with S1 during stalls.
- Counters (advance on accept):
  - pix_cnt wraps at Image_size²−1, then ch_cnt increments.
  - ch_cnt wraps at Channel_size−1.
  - On an accepted tlast, both counters reset to 0.
  - If that tlast does not coincide with pix_cnt = Image_size²−1 and ch_cnt = Channel_size−1, frame_error is set. It is cleared only by reset.
- S2 arithmetic:
  - p = noise × scale, signed 32-bit Q16.16; p = 0 if noise_en = 0.
  - sum = sext49(acc) + sext49(p).
  - y = sum if act_en = 0 or sum ≥ 0, otherwise (sum × 13) >>> 6 (arithmetic, floor).
- S3: r = (y + 2^(SHIFT−1)) >>> SHIFT, saturated to [−32768, 32767]. This is m_axis_tdata.
- m_axis_tlast is the pipelined input tlast.

## Timing
- Latency: an accepted beat appears on m_axis 3 cycles later when there is no backpressure. Throughput is 1 beat/cycle.
- m_axis_tvalid & m_axis_tdata stay stable until m_axis_tready. With ce low, every stage and both counters freeze.
- s_axis_tready depends combinationally on m_axis_tready; there is no combinational path from s_axis to m_axis.
- Reset (asynchronous, any cycle) clears:
  - all valid bits, m_axis_tvalid, m_axis_tlast and m_axis_tdata to 0
  - pix_cnt, ch_cnt and frame_error to 0
- While reset is high: s_axis_tready = 0, noise_BRAM_en = 0, noise_scale_BRAM_en = 0. In-flight beats are discarded.
- Bubbles: when ce = 1 and s_axis_tvalid = 0, S1 loads invalid and no BRAM read is issued.
- Image_size / Channel_size change only while the pipeline is idle. Behaviour is undefined otherwise.

## Test plan
1. Passthrough: noise_en = 0, act_en = 0, acc = 0x1234 -> m_axis_tdata = 0x0012, exactly 3 cycles after accept.
2. LeakyReLU: act_en = 1, acc = −25600 -> y = −5200, m_axis_tdata = 0xFFEC. Acc = +25600 -> 0x0064.
3. Noise: noise = 0x0100, scale = 0x0080, acc = 0 -> 0x0080. Check noise_BRAM_addr = pix_cnt and noise_scale_BRAM_addr = ch_cnt on each accept.
4. Saturation: acc = 2³², act_en = 0 -> 0x7FFF. Acc = −2³² -> 0x8000. Acc = −2³², act_en = 1 -> 0x8000.
5. Backpressure: Image_size = 4, Channel_size = 2, 32 beats with random tvalid and m_axis_tready low for 5 cycles mid-stream -> no loss or duplication, order kept, noise addresses 0..15 twice, scale address 0 then 1, m_axis_tlast only on beat 32, frame_error = 0.
6. Early tlast on beat 10 -> frame_error = 1 and the next accept uses addresses 0/0. Reset asserted mid-stream -> m_axis_tvalid = 0 immediately and counters = 0; frame_error clears.

Source files
------------

// File: rtl/noise_leakyrelu_stage_if.sv
// AXI-Stream style bundle: data, valid/ready handshake and end-of-frame marker.
// W sets the tdata width so the same bundle serves the wide input and narrow output.
// master drives tdata/tvalid/tlast, slave drives tready.
interface noise_leakyrelu_stage_if #(
    parameter int W = 64
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/noise_leakyrelu_stage.sv
// Adds scaled per-pixel noise to a conv accumulator, applies LeakyReLU, rounds/saturates to Q8.8.
// Latency 3 cycles (capture, noise+activation, round/saturate), 1 beat/cycle throughput.
// Backpressure: one global advance; m_axis_tready low with a valid output freezes all stages, counters and s_axis_tready.
module noise_leakyrelu_stage #(
    parameter int ACC_WIDTH  = 48,
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            Image_size,
    input  logic [8:0]            Channel_size,
    input  logic                  noise_en,
    input  logic                  act_en,
    output logic [13:0]           noise_BRAM_addr,
    output logic                  noise_BRAM_en,
    input  logic [DATA_WIDTH-1:0] noise_BRAM_dout,
    output logic [7:0]            noise_scale_BRAM_addr,
    output logic                  noise_scale_BRAM_en,
    input  logic [DATA_WIDTH-1:0] noise_scale_BRAM_dout,
    noise_leakyrelu_stage_if.slave  s_axis,
    noise_leakyrelu_stage_if.master m_axis,
    output logic                  frame_error
);
    localparam int SUM_W  = ACC_WIDTH + 1;
    localparam int MUL_W  = SUM_W + 4;
    localparam int RND_W  = SUM_W + 1;
    localparam int PROD_W = 2 * DATA_WIDTH;

    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-(2 ** (DATA_WIDTH - 1)));

    logic ce;
    logic accept;

    logic [13:0] pix_cnt;
    logic [7:0]  ch_cnt;
    logic [15:0] pix_last;
    logic [8:0]  ch_last;
    logic        pix_wrap;
    logic        ch_wrap;

    logic                 s1_vld, s1_last;
    logic [ACC_WIDTH-1:0] s1_acc;
    logic                 s2_vld, s2_last;
    logic [SUM_W-1:0]     s2_y;
    logic                 m_vld, m_last;
    logic [DATA_WIDTH-1:0] m_dat;

    logic signed [PROD_W-1:0] noise_ext, scale_ext, prod;
    logic signed [SUM_W-1:0]  sum;
    logic signed [MUL_W-1:0]  leak, leak_sh;
    logic [SUM_W-1:0]         y_next;
    logic signed [RND_W-1:0]  rnd, rnd_sh;
    logic [DATA_WIDTH-1:0]    pix_next;

    // Upper accumulator bits carry nothing in Q32.16 and are dropped.
    logic unused_tdata_hi;
    assign unused_tdata_hi = ^s_axis.tdata[$bits(s_axis.tdata)-1:ACC_WIDTH];

    assign ce             = ~reset & (~m_vld | m_axis.tready);
    assign accept         = s_axis.tvalid & ce;
    assign s_axis.tready  = ce;

    // BRAM reads are issued only on accept so their held dout stays aligned with S1 during stalls.
    assign noise_BRAM_addr       = pix_cnt;
    assign noise_BRAM_en         = accept;
    assign noise_scale_BRAM_addr = ch_cnt;
    assign noise_scale_BRAM_en   = accept;

    assign pix_last = 16'(Image_size) * 16'(Image_size) - 16'd1;
    assign ch_last  = Channel_size - 9'd1;
    assign pix_wrap = ({2'b00, pix_cnt} == pix_last);
    assign ch_wrap  = ({1'b0, ch_cnt} == ch_last);

    // Pixel/channel address counters; tlast restarts the frame and flags a misaligned end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt     <= '0;
            ch_cnt      <= '0;
            frame_error <= 1'b0;
        end else if (accept) begin
            if (s_axis.tlast) begin
                pix_cnt <= '0;
                ch_cnt  <= '0;
                if (!(pix_wrap && ch_wrap)) begin
                    frame_error <= 1'b1;
                end
            end else if (pix_wrap) begin
                pix_cnt <= '0;
                ch_cnt  <= ch_wrap ? 8'd0 : ch_cnt + 8'd1;
            end else begin
                pix_cnt <= pix_cnt + 14'd1;
            end
        end
    end

    // S1: capture accumulator; a bubble loads an invalid slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_acc  <= '0;
        end else if (ce) begin
            s1_vld  <= s_axis.tvalid;
            s1_last <= s_axis.tvalid & s_axis.tlast;
            if (accept) begin
                s1_acc <= s_axis.tdata[ACC_WIDTH-1:0];
            end
        end
    end

    // S2 datapath: noise*scale added to the accumulator, then LeakyReLU with slope 13/64.
    always_comb begin
        noise_ext = PROD_W'($signed(noise_BRAM_dout));
        scale_ext = PROD_W'($signed(noise_scale_BRAM_dout));
        prod      = '0;
        if (noise_en) begin
            prod = noise_ext * scale_ext;
        end
        sum     = {s1_acc[ACC_WIDTH-1], s1_acc} + {{(SUM_W - PROD_W){prod[PROD_W-1]}}, prod};
        leak    = {{(MUL_W - SUM_W){sum[SUM_W-1]}}, sum} * MUL_W'(13);
        leak_sh = leak >>> 6;
        y_next  = (act_en && sum[SUM_W-1]) ? leak_sh[SUM_W-1:0] : sum;
    end

    // S2 register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_y    <= '0;
        end else if (ce) begin
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            s2_y    <= y_next;
        end
    end

    // S3 datapath: round half-up to Q8.8 and clamp to the signed output range.
    always_comb begin
        rnd    = {s2_y[SUM_W-1], s2_y} + RND_W'(2 ** (SHIFT - 1));
        rnd_sh = rnd >>> SHIFT;
        if (rnd_sh > SAT_MAX) begin
            pix_next = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (rnd_sh < SAT_MIN) begin
            pix_next = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end else begin
            pix_next = rnd_sh[DATA_WIDTH-1:0];
        end
    end

    // S3 output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_vld  <= 1'b0;
            m_last <= 1'b0;
            m_dat  <= '0;
        end else if (ce) begin
            m_vld  <= s2_vld;
            m_last <= s2_last;
            m_dat  <= pix_next;
        end
    end

    assign m_axis.tvalid = m_vld;
    assign m_axis.tlast  = m_last;
    assign m_axis.tdata  = m_dat;
endmodule

// File: tb/tb_noise_leakyrelu_stage.sv
// Bench for noise_leakyrelu_stage: scoreboard of expected beats plus per-scenario checks.
module tb_noise_leakyrelu_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  image_size;
    logic [8:0]  channel_size;
    logic        noise_en, act_en;
    logic [13:0] noise_addr;
    logic        noise_bram_en;
    logic [15:0] noise_dout;
    logic [7:0]  scale_addr;
    logic        scale_bram_en;
    logic [15:0] scale_dout;
    logic        frame_error;

    noise_leakyrelu_stage_if #(.W(64)) s_if ();
    noise_leakyrelu_stage_if #(.W(16)) m_if ();

    always #5 clk = ~clk;

    noise_leakyrelu_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .Image_size            (image_size),
        .Channel_size          (channel_size),
        .noise_en              (noise_en),
        .act_en                (act_en),
        .noise_BRAM_addr       (noise_addr),
        .noise_BRAM_en         (noise_bram_en),
        .noise_BRAM_dout       (noise_dout),
        .noise_scale_BRAM_addr (scale_addr),
        .noise_scale_BRAM_en   (scale_bram_en),
        .noise_scale_BRAM_dout (scale_dout),
        .s_axis                (s_if),
        .m_axis                (m_if),
        .frame_error           (frame_error)
    );

    logic [15:0] noise_mem [0:16383];
    logic [15:0] scale_mem [0:255];

    // BRAM models: 1-cycle read latency, dout holds while en is low.
    always @(posedge clk) begin
        if (noise_bram_en) noise_dout <= noise_mem[noise_addr];
        if (scale_bram_en) scale_dout <= scale_mem[scale_addr];
    end

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    logic [16:0] exp_q [$];
    logic [15:0] obs_q [$];
    logic [16:0] mon_e;
    int tb_pix, tb_ch;
    bit tb_ferr;

    function automatic logic [15:0] model(input logic [47:0] acc, input logic [15:0] n, input logic [15:0] s);
        longint a, p, sm, y, r;
        a  = longint'($signed(acc));
        p  = noise_en ? longint'($signed(n)) * longint'($signed(s)) : 64'sd0;
        sm = a + p;
        y  = (act_en && sm < 0) ? ((sm * 13) >>> 6) : sm;
        r  = (y + 128) >>> 8;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    // Output monitor: every transfer is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!reset && m_if.tvalid && m_if.tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got last=%b data=%h, none expected", m_if.tlast, m_if.tdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({m_if.tlast, m_if.tdata} !== mon_e) begin
                    errors++;
                    $display("FAIL out_beat%0d got last=%b data=%h, expected last=%b data=%h",
                             out_cnt, m_if.tlast, m_if.tdata, mon_e[16], mon_e[15:0]);
                end
            end
            obs_q.push_back(m_if.tdata);
            out_cnt++;
        end
    end

    task automatic send(input logic [47:0] acc, input bit last);
        int t;
        s_if.tdata  = {16'hDEAD, acc};
        s_if.tvalid = 1'b1;
        s_if.tlast  = last;
        t = 0;
        forever begin
            @(negedge clk);
            if (s_if.tready) break;
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout got no s_axis_tready within 200 cycles");
                s_if.tvalid = 1'b0;
                return;
            end
        end
        checks++;
        if (noise_addr !== 14'(tb_pix) || scale_addr !== 8'(tb_ch) || noise_bram_en !== 1'b1 || scale_bram_en !== 1'b1) begin
            errors++;
            $display("FAIL bram_addr got pix=%0d ch=%0d en=%b%b, expected pix=%0d ch=%0d en=11",
                     noise_addr, scale_addr, noise_bram_en, scale_bram_en, tb_pix, tb_ch);
        end
        exp_q.push_back({last, model(acc, noise_mem[tb_pix], scale_mem[tb_ch])});
        if (last) begin
            if (!(tb_pix == int'(image_size) * int'(image_size) - 1 && tb_ch == int'(channel_size) - 1)) tb_ferr = 1'b1;
            tb_pix = 0;
            tb_ch  = 0;
        end else if (tb_pix == int'(image_size) * int'(image_size) - 1) begin
            tb_pix = 0;
            tb_ch  = (tb_ch == int'(channel_size) - 1) ? 0 : tb_ch + 1;
        end else begin
            tb_pix++;
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        m_if.tready = 1'b1;
        t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d beats still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        tb_pix  = 0;
        tb_ch   = 0;
        tb_ferr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        s_if.tvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out got vld=%b last=%b data=%h, expected 0 0 0000", m_if.tvalid, m_if.tlast, m_if.tdata);
        end
        checks++;
        if (s_if.tready !== 1'b0 || noise_bram_en !== 1'b0 || scale_bram_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got rdy=%b en=%b%b, expected 0 00", s_if.tready, noise_bram_en, scale_bram_en);
        end
        checks++;
        if (noise_addr !== 14'd0 || scale_addr !== 8'd0 || frame_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt got pix=%0d ch=%0d ferr=%b, expected 0 0 0", noise_addr, scale_addr, frame_error);
        end
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        int k;
        noise_en = 1'b0;
        act_en   = 1'b0;
        obs_q.delete();
        send(48'h1234, 1'b0);
        k = 0;
        while (k < 6) begin
            @(negedge clk);
            k++;
            if (m_if.tvalid) break;
        end
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL latency got %0d cycles, expected 3", k);
        end
        drain();
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== 16'h0012) begin
            errors++;
            $display("FAIL passthrough got n=%0d data=%h, expected 1 beat 0012", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_leaky();
        noise_en = 1'b0;
        act_en   = 1'b1;
        obs_q.delete();
        send(48'(-25600), 1'b0);
        send(48'(25600), 1'b0);
        drain();
        checks++;
        if (obs_q.size() !== 2 || obs_q[0] !== 16'hFFEC || obs_q[1] !== 16'h0064) begin
            errors++;
            $display("FAIL leaky got n=%0d, expected 2 beats FFEC 0064", obs_q.size());
        end
    endtask

    task automatic test_noise();
        noise_en = 1'b1;
        act_en   = 1'b0;
        obs_q.delete();
        noise_mem[tb_pix] = 16'h0100;
        scale_mem[tb_ch]  = 16'h0080;
        send(48'h0, 1'b0);
        drain();
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== 16'h0080) begin
            errors++;
            $display("FAIL noise got n=%0d data=%h, expected 1 beat 0080", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 16'hxxxx);
        end
        noise_en = 1'b0;
    endtask

    task automatic test_saturation();
        noise_en = 1'b0;
        act_en   = 1'b0;
        obs_q.delete();
        send(48'h0001_0000_0000, 1'b0);
        send(48'hFFFF_0000_0000, 1'b0);
        drain();
        act_en = 1'b1;
        send(48'hFFFF_0000_0000, 1'b0);
        drain();
        checks++;
        if (obs_q.size() !== 3 || obs_q[0] !== 16'h7FFF || obs_q[1] !== 16'h8000 || obs_q[2] !== 16'h8000) begin
            errors++;
            $display("FAIL saturation got n=%0d, expected 3 beats 7FFF 8000 8000", obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int out0;
        do_reset();
        noise_en = 1'b1;
        act_en   = 1'b1;
        for (int i = 0; i < 16; i++) noise_mem[i] = 16'(int'($urandom_range(0, 8191)) - 4096);
        for (int i = 0; i < 2; i++) scale_mem[i] = 16'(int'($urandom_range(0, 2047)) - 1024);
        out0 = out_cnt;
        fork
            begin
                for (int i = 1; i <= 32; i++) begin
                    send(48'(int'($urandom_range(0, 2097152)) - 1048576), i == 32);
                    if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
                end
            end
            begin
                idle(12);
                m_if.tready = 1'b0;
                idle(5);
                m_if.tready = 1'b1;
            end
        join
        drain();
        checks++;
        if (out_cnt - out0 !== 32) begin
            errors++;
            $display("FAIL b2b_count got %0d beats, expected 32", out_cnt - out0);
        end
        checks++;
        if (frame_error !== tb_ferr) begin
            errors++;
            $display("FAIL b2b_frame_error got %b, expected %b", frame_error, tb_ferr);
        end
    endtask

    task automatic test_frame_error();
        do_reset();
        noise_en = 1'b0;
        act_en   = 1'b0;
        for (int i = 1; i <= 10; i++) send(48'(i * 256), i == 10);
        @(negedge clk);
        checks++;
        if (frame_error !== 1'b1) begin
            errors++;
            $display("FAIL early_tlast got frame_error=%b, expected 1", frame_error);
        end
        checks++;
        if (noise_addr !== 14'd0 || scale_addr !== 8'd0) begin
            errors++;
            $display("FAIL early_tlast_addr got pix=%0d ch=%0d, expected 0 0", noise_addr, scale_addr);
        end
        @(posedge clk);
        #1;
        send(48'h0500, 1'b0);
        send(48'h0600, 1'b0);
        send(48'h0700, 1'b0);
        checks++;
        if (m_if.tvalid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_vld got %b, expected 1", m_if.tvalid);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || frame_error !== 1'b0 || noise_addr !== 14'd0 || scale_addr !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset got vld=%b ferr=%b pix=%0d ch=%0d, expected 0 0 0 0",
                     m_if.tvalid, frame_error, noise_addr, scale_addr);
        end
        exp_q.delete();
        tb_pix  = 0;
        tb_ch   = 0;
        tb_ferr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs_q.delete();
        send(48'h1234, 1'b0);
        drain();
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== 16'h0012) begin
            errors++;
            $display("FAIL post_reset got n=%0d, expected 1 beat 0012", obs_q.size());
        end
    endtask

    initial begin
        reset        = 1'b1;
        image_size   = 8'd4;
        channel_size = 9'd2;
        noise_en     = 1'b0;
        act_en       = 1'b0;
        s_if.tdata   = '0;
        s_if.tvalid  = 1'b0;
        s_if.tlast   = 1'b0;
        m_if.tready  = 1'b1;
        tb_pix       = 0;
        tb_ch        = 0;
        tb_ferr      = 1'b0;
        for (int i = 0; i < 16384; i++) noise_mem[i] = 16'h0;
        for (int i = 0; i < 256; i++) scale_mem[i] = 16'h0;
        test_reset();
        test_passthrough();
        test_leaky();
        test_noise();
        test_saturation();
        test_back_to_back();
        test_frame_error();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout got no completion, expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
